// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the
// data memory (slave).
interface mem_stage_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic                  dmem_ack;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: runs loads/stores on the req/ack data bus with a bounded
// timeout, stalls upstream while an access is pending, registers MEM/WB outputs.
module mem_stage #(
    parameter int PC_WIDTH      = 12,
    parameter int DATA_WIDTH    = 16,
    parameter int REGADDR_WIDTH = 3,
    parameter int ADDR_WIDTH    = 12,
    parameter int TIMEOUT       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_reg_write,
    input  logic                     mem_mem_read,
    input  logic                     mem_mem_write,
    input  logic                     mem_branch,
    input  logic [PC_WIDTH-1:0]      mem_pc,
    input  logic [DATA_WIDTH-1:0]    mem_alu_result,
    input  logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic [REGADDR_WIDTH-1:0] mem_rd,
    mem_stage_if.master              dmem,
    output logic                     stall,
    output logic                     pc_src,
    output logic [PC_WIDTH-1:0]      branch_target,
    output logic                     bus_error,
    output logic                     wb_reg_write,
    output logic                     wb_mem_to_reg,
    output logic [DATA_WIDTH-1:0]    wb_alu_result,
    output logic [DATA_WIDTH-1:0]    wb_read_data,
    output logic [REGADDR_WIDTH-1:0] wb_rd,
    output logic [PC_WIDTH-1:0]      wb_pc
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic                     we_q, we_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    alu_q, alu_d;
    logic [REGADDR_WIDTH-1:0] rd_q, rd_d;
    logic                     regw_q, regw_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic                     read_q, read_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic                     bus_error_q, bus_error_d;
    logic                     wb_reg_write_q, wb_reg_write_d;
    logic                     wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [DATA_WIDTH-1:0]    wb_alu_result_q, wb_alu_result_d;
    logic [DATA_WIDTH-1:0]    wb_read_data_q, wb_read_data_d;
    logic [REGADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic [PC_WIDTH-1:0]      wb_pc_q, wb_pc_d;
    logic                     stall_c;
    logic                     mem_op;

    assign mem_op = mem_mem_read | mem_mem_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            addr_q          <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            alu_q           <= '0;
            rd_q            <= '0;
            regw_q          <= 1'b0;
            pc_q            <= '0;
            read_q          <= 1'b0;
            rdata_q         <= '0;
            err_q           <= 1'b0;
            bus_error_q     <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_alu_result_q <= '0;
            wb_read_data_q  <= '0;
            wb_rd_q         <= '0;
            wb_pc_q         <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            addr_q          <= addr_d;
            we_q            <= we_d;
            wdata_q         <= wdata_d;
            alu_q           <= alu_d;
            rd_q            <= rd_d;
            regw_q          <= regw_d;
            pc_q            <= pc_d;
            read_q          <= read_d;
            rdata_q         <= rdata_d;
            err_q           <= err_d;
            bus_error_q     <= bus_error_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_rd_q         <= wb_rd_d;
            wb_pc_q         <= wb_pc_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        we_d            = we_q;
        wdata_d         = wdata_q;
        alu_d           = alu_q;
        rd_d            = rd_q;
        regw_d          = regw_q;
        pc_d            = pc_q;
        read_d          = read_q;
        rdata_d         = rdata_q;
        err_d           = err_q;
        bus_error_d     = 1'b0;
        wb_reg_write_d  = wb_reg_write_q;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        wb_alu_result_d = wb_alu_result_q;
        wb_read_data_d  = wb_read_data_q;
        wb_rd_d         = wb_rd_q;
        wb_pc_d         = wb_pc_q;
        stall_c         = 1'b0;
        pc_src          = 1'b0;

        unique case (state_q)
            IDLE: begin
                pc_src = mem_branch & (mem_alu_result == '0);
                if (mem_op) begin
                    stall_c = 1'b1;
                    state_d = ACCESS;
                    addr_d  = mem_alu_result[ADDR_WIDTH-1:0];
                    // A simultaneous read+write request is executed as a store.
                    we_d    = mem_mem_write;
                    read_d  = mem_mem_read & ~mem_mem_write;
                    wdata_d = mem_write_data;
                    alu_d   = mem_alu_result;
                    rd_d    = mem_rd;
                    regw_d  = mem_reg_write;
                    pc_d    = mem_pc;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    wb_reg_write_d  = 1'b0;
                    wb_mem_to_reg_d = 1'b0;
                    wb_alu_result_d = '0;
                    wb_read_data_d  = '0;
                    wb_rd_d         = '0;
                    wb_pc_d         = '0;
                end else begin
                    wb_reg_write_d  = mem_reg_write;
                    wb_mem_to_reg_d = 1'b0;
                    wb_alu_result_d = mem_alu_result;
                    wb_read_data_d  = '0;
                    wb_rd_d         = mem_rd;
                    wb_pc_d         = mem_pc;
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                // An ack in the last allowed cycle takes priority over the timeout.
                if (dmem.dmem_ack) begin
                    rdata_d = dmem.dmem_rdata;
                    state_d = COMPLETE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d       = 1'b1;
                    bus_error_d = 1'b1;
                    state_d     = COMPLETE;
                end
            end
            COMPLETE: begin
                wb_reg_write_d  = regw_q & ~err_q;
                wb_mem_to_reg_d = read_q;
                wb_alu_result_d = alu_q;
                wb_read_data_d  = err_q ? '0 : rdata_q;
                wb_rd_d         = rd_q;
                wb_pc_d         = pc_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall           = stall_c & ~reset;
    assign branch_target   = mem_pc;
    assign bus_error       = bus_error_q;
    assign dmem.dmem_req   = (state_q == ACCESS);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign wb_reg_write    = wb_reg_write_q;
    assign wb_mem_to_reg   = wb_mem_to_reg_q;
    assign wb_alu_result   = wb_alu_result_q;
    assign wb_read_data    = wb_read_data_q;
    assign wb_rd           = wb_rd_q;
    assign wb_pc           = wb_pc_q;
endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, hand-written reset/branch
// sequences and randomized operations checked against a transaction-level model.
module tb_mem_stage;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_branch;
    logic [11:0] mem_pc;
    logic [15:0] mem_alu_result, mem_write_data;
    logic [2:0]  mem_rd;
    logic        stall, pc_src, bus_error;
    logic [11:0] branch_target, wb_pc;
    logic        wb_reg_write, wb_mem_to_reg;
    logic [15:0] wb_alu_result, wb_read_data;
    logic [2:0]  wb_rd;

    int checks = 0;
    int failures = 0;

    mem_stage_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) bus ();

    mem_stage #(
        .PC_WIDTH(12), .DATA_WIDTH(16), .REGADDR_WIDTH(3),
        .ADDR_WIDTH(12), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_branch(mem_branch),
        .mem_pc(mem_pc), .mem_alu_result(mem_alu_result),
        .mem_write_data(mem_write_data), .mem_rd(mem_rd),
        .dmem(bus.master),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .bus_error(bus_error), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_alu_result(wb_alu_result),
        .wb_read_data(wb_read_data), .wb_rd(wb_rd), .wb_pc(wb_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw, rd, wr;
        logic [11:0] pc;
        logic [15:0] alu, wdata, rdata;
        logic [2:0]  rdst;
        int          delay;      // ack in this ACCESS cycle; 0 = never
        int          exp_stall;
        logic        exp_regw, exp_mtr, exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Transaction-level expectation: a memory op costs one issue cycle plus the
    // number of request cycles, which is the ack delay or the full timeout.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic ok;
        ok = (v.delay >= 1) && (v.delay <= TIMEOUT);
        if (!(v.rd | v.wr)) begin
            r.exp_stall = 0;
            r.exp_regw  = v.rw;
            r.exp_mtr   = 1'b0;
            r.exp_err   = 1'b0;
            r.exp_rdata = '0;
        end else begin
            r.exp_stall = (ok ? v.delay : TIMEOUT) + 1;
            r.exp_regw  = v.rw & ok;
            r.exp_mtr   = v.rd & ~v.wr;
            r.exp_err   = ~ok;
            r.exp_rdata = ok ? v.rdata : 16'h0;
        end
        return r;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        int stallc = 0, reqc = 0, errc = 0;
        bit done = 0;
        @(negedge clk);
        mem_reg_write = v.rw; mem_mem_read = v.rd; mem_mem_write = v.wr;
        mem_branch = 1'b0; mem_pc = v.pc; mem_alu_result = v.alu;
        mem_write_data = v.wdata; mem_rd = v.rdst;
        bus.dmem_ack = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus_error) errc++;
            if (!stall) begin done = 1; break; end
            stallc++;
            if (bus.dmem_req) begin
                reqc++;
                if (reqc == 1) begin
                    chk({nm, ".addr"}, 32'(bus.dmem_addr), 32'(v.alu[11:0]));
                    chk({nm, ".we"}, 32'(bus.dmem_we), 32'(v.wr));
                    chk({nm, ".bubble"}, 32'(wb_reg_write), 32'd0);
                    if (v.wr) chk({nm, ".wdata"}, 32'(bus.dmem_wdata), 32'(v.wdata));
                end
                bus.dmem_ack   = (reqc == v.delay);
                bus.dmem_rdata = (reqc == v.delay) ? v.rdata : 16'($urandom);
            end
            @(negedge clk);
            bus.dmem_ack = 1'b0;
        end
        if (!done) begin
            chk({nm, ".stall_bounded"}, 32'd1, 32'd0);
            return;
        end
        chk({nm, ".stall_cycles"}, 32'(stallc), 32'(v.exp_stall));
        chk({nm, ".req_cycles"}, 32'(reqc), 32'(v.exp_stall > 0 ? v.exp_stall - 1 : 0));
        chk({nm, ".bus_error"}, 32'(errc), 32'(v.exp_err));
        @(posedge clk);
        #1;
        chk({nm, ".wb_reg_write"}, 32'(wb_reg_write), 32'(v.exp_regw));
        chk({nm, ".wb_mem_to_reg"}, 32'(wb_mem_to_reg), 32'(v.exp_mtr));
        chk({nm, ".wb_alu_result"}, 32'(wb_alu_result), 32'(v.alu));
        chk({nm, ".wb_rd"}, 32'(wb_rd), 32'(v.rdst));
        chk({nm, ".wb_pc"}, 32'(wb_pc), 32'(v.pc));
        if (v.exp_mtr) chk({nm, ".wb_read_data"}, 32'(wb_read_data), 32'(v.exp_rdata));
        chk({nm, ".bus_error_after"}, 32'(bus_error), 32'd0);
    endtask

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //       rw    rd    wr    pc      alu       wdata     rdata     rdst  dly stl regw  mtr   err   exp_rdata
        tbl[0] = '{1'b1, 1'b0, 1'b0, 12'h010, 16'h1234, 16'h0000, 16'h0000, 3'd5, 0, 0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 12'h014, 16'h0040, 16'h0000, 16'hBEEF, 3'd2, 2, 3, 1'b1, 1'b1, 1'b0, 16'hBEEF};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 12'h018, 16'h0100, 16'hA5A5, 16'h1111, 3'd0, 1, 2, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 12'h01C, 16'h0200, 16'h0000, 16'hDEAD, 3'd3, 0, 9, 1'b0, 1'b1, 1'b1, 16'h0000};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 12'h020, 16'h0777, 16'h0000, 16'h0000, 3'd7, 0, 0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 12'h024, 16'h0300, 16'h0000, 16'h5A5A, 3'd4, 8, 9, 1'b1, 1'b1, 1'b0, 16'h5A5A};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 12'h028, 16'h0404, 16'h3C3C, 16'h2222, 3'd6, 1, 2, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 12'h02C, 16'hF080, 16'h0000, 16'h7E57, 3'd1, 1, 2, 1'b1, 1'b1, 1'b0, 16'h7E57};

        reset = 1'b1;
        mem_reg_write = 0; mem_mem_read = 0; mem_mem_write = 0; mem_branch = 0;
        mem_pc = '0; mem_alu_result = '0; mem_write_data = '0; mem_rd = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.req", 32'(bus.dmem_req), 32'd0);
        chk("reset.wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("reset.bus_error", 32'(bus_error), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Branch resolution, and pc_src suppressed once an access is underway.
        @(negedge clk);
        mem_branch = 1'b1; mem_alu_result = 16'h0000; mem_pc = 12'h0A0;
        #1;
        chk("branch.taken", 32'(pc_src), 32'd1);
        chk("branch.target", 32'(branch_target), 32'h0A0);
        mem_alu_result = 16'h0003;
        #1;
        chk("branch.not_taken", 32'(pc_src), 32'd0);
        mem_alu_result = 16'h0000; mem_mem_read = 1'b1; mem_reg_write = 1'b1;
        @(posedge clk);
        #1;
        chk("branch.access_req", 32'(bus.dmem_req), 32'd1);
        chk("branch.access_pc_src", 32'(pc_src), 32'd0);
        @(negedge clk);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 16'h0001;
        @(posedge clk);
        #1;
        chk("branch.complete_pc_src", 32'(pc_src), 32'd0);
        @(negedge clk);
        mem_branch = 1'b0; mem_mem_read = 1'b0; mem_reg_write = 1'b0;
        // Stray ack while idle must not start anything.
        bus.dmem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        #1;
        chk("stray_ack.req", 32'(bus.dmem_req), 32'd0);
        chk("stray_ack.stall", 32'(stall), 32'd0);

        // Reset in the middle of an access abandons it immediately.
        mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_alu_result = 16'h0333;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midreset.req_before", 32'(bus.dmem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midreset.req", 32'(bus.dmem_req), 32'd0);
        chk("midreset.stall", 32'(stall), 32'd0);
        chk("midreset.wb_alu_result", 32'(wb_alu_result), 32'd0);
        @(negedge clk);
        mem_mem_read = 1'b0; mem_reg_write = 1'b0; mem_alu_result = '0;
        reset = 1'b0;
        apply(tbl[1], "post_reset_load");

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            int kind = $urandom_range(0, 3);
            v.rw    = 1'($urandom);
            v.rd    = (kind == 1) || (kind == 3);
            v.wr    = (kind == 2) || (kind == 3 && ($urandom_range(0, 1) == 1));
            v.pc    = 12'($urandom);
            v.alu   = 16'($urandom);
            v.wdata = 16'($urandom);
            v.rdata = 16'($urandom);
            v.rdst  = 3'($urandom);
            v.delay = $urandom_range(0, 10);
            v = model(v);
            apply(v, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
